// File: rtl/coin_credit_bcd.sv
// Coin credit accumulator with vend/refund handling and a sequential
// double-dabble BCD converter for the LCD path. Optional refund: REFUND_EN.
//
// Ports:
//   sys_clk, sys_rst_n    clock, async active-low reset
//   coin_pulse[CH_NUM]    one-cycle coin pulses, per channel
//   vend_req, vend_price  vend request level and price
//   vend_ack, vend_nak    vend outcome pulses
//   coin_reject           coins refused this cycle (would overflow credit)
//   coin_val_sum          current credit (binary)
//   sum_bcd, bcd_valid    last BCD conversion, update pulse
//   bcd_busy              conversion in progress
//   refund_req/val/done   only when REFUND_EN is defined
module coin_credit_bcd #(
  parameter int CH_NUM     = 3,
  parameter int SUM_W      = 11,
  parameter int DIGITS     = 4,
  parameter int CREDIT_MAX = 1999,
  parameter logic [CH_NUM*SUM_W-1:0] COIN_VALS =
    {11'd100, 11'd50, 11'd10}
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [CH_NUM-1:0]     coin_pulse,
  input  logic                  vend_req,
  input  logic [SUM_W-1:0]      vend_price,
`ifdef REFUND_EN
  input  logic                  refund_req,
  output logic [SUM_W-1:0]      refund_val,
  output logic                  refund_done,
`endif
  output logic                  vend_ack,
  output logic                  vend_nak,
  output logic                  coin_reject,
  output logic [SUM_W-1:0]      coin_val_sum,
  output logic [4*DIGITS-1:0]   sum_bcd,
  output logic                  bcd_valid,
  output logic                  bcd_busy
);

  localparam int AW    = SUM_W + $clog2(CH_NUM + 1) + 1;
  localparam int CNT_W = $clog2(SUM_W);
  localparam int BW    = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  logic [SUM_W-1:0] credit;
  logic [SUM_W-1:0] credit_d;
  logic [SUM_W-1:0] base;
  logic [AW-1:0]    add;
  logic [AW-1:0]    total;
  logic             vend_req_d;
  logic             vend_edge;
  logic             refund_edge;
  logic             ack_d;
  logic             nak_d;
  logic             rej_d;
  logic             chg;

  state_t           state;
  state_t           state_d;
  logic             pending;
  logic [SUM_W-1:0] snap;
  logic [BW-1:0]    bcd;
  logic [BW-1:0]    bcd_adj;
  logic [CNT_W-1:0] cnt;

  assign vend_edge    = vend_req & ~vend_req_d;
  assign coin_val_sum = credit;
  assign bcd_busy     = (state != IDLE);

`ifdef REFUND_EN
  logic refund_req_d;

  assign refund_edge = refund_req & ~refund_req_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      refund_req_d <= 1'b0;
      refund_val   <= '0;
      refund_done  <= 1'b0;
    end else begin
      refund_req_d <= refund_req;
      refund_done  <= refund_edge;
      if (refund_edge) refund_val <= credit;
    end
  end
`else
  assign refund_edge = 1'b0;
`endif

  always_comb begin
    add = '0;
    for (int i = 0; i < CH_NUM; i++)
      if (coin_pulse[i])
        add = add + AW'(COIN_VALS[i*SUM_W +: SUM_W]);
  end

  // Vend compares against pre-coin credit; a refund
  // in the same cycle wins and the vend is refused.
  always_comb begin
    ack_d = 1'b0;
    nak_d = 1'b0;
    base  = credit;
    if (vend_edge) begin
      if (!refund_edge && credit >= vend_price) begin
        ack_d = 1'b1;
        base  = credit - vend_price;
      end else begin
        nak_d = 1'b1;
      end
    end
    if (refund_edge) base = '0;
    total    = AW'(base) + add;
    rej_d    = (total > AW'(CREDIT_MAX));
    credit_d = rej_d ? base : total[SUM_W-1:0];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      credit      <= '0;
      vend_req_d  <= 1'b0;
      vend_ack    <= 1'b0;
      vend_nak    <= 1'b0;
      coin_reject <= 1'b0;
      chg         <= 1'b0;
    end else begin
      credit      <= credit_d;
      vend_req_d  <= vend_req;
      vend_ack    <= ack_d;
      vend_nak    <= nak_d;
      coin_reject <= rej_d;
      chg         <= (credit_d != credit);
    end
  end

  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < DIGITS; d++)
      if (bcd[d*4 +: 4] >= 4'd5)
        bcd_adj[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (chg || pending) state_d = SHIFT;
      SHIFT:   if (cnt == CNT_W'(SUM_W - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // chg flags a credit update on the previous edge; one seen
  // mid-conversion is remembered and served once back in IDLE.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      pending   <= 1'b0;
      snap      <= '0;
      bcd       <= '0;
      cnt       <= '0;
      sum_bcd   <= '0;
      bcd_valid <= 1'b0;
    end else begin
      state     <= state_d;
      bcd_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (chg || pending) begin
            snap    <= credit;
            bcd     <= '0;
            cnt     <= '0;
            pending <= 1'b0;
          end
        end
        SHIFT: begin
          bcd  <= {bcd_adj[BW-2:0], snap[SUM_W-1]};
          snap <= snap << 1;
          cnt  <= cnt + CNT_W'(1);
          if (chg) pending <= 1'b1;
        end
        DONE: begin
          sum_bcd   <= bcd;
          bcd_valid <= 1'b1;
          if (chg) pending <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_coin_credit_bcd.sv
// Testbench for coin_credit_bcd: directed scenarios plus
// randomized traffic against a behavioural credit model.
module tb_coin_credit_bcd;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [2:0]  coin_pulse = '0;
  logic        vend_req = 1'b0;
  logic [10:0] vend_price = '0;
  logic        vend_ack, vend_nak, coin_reject;
  logic        bcd_valid, bcd_busy;
  logic [10:0] coin_val_sum;
  logic [15:0] sum_bcd;
`ifdef REFUND_EN
  logic        refund_req = 1'b0;
  logic [10:0] refund_val;
  logic        refund_done;
`endif

  int n_chk = 0;
  int n_pass = 0;

  int m_credit = 0;
  bit m_vd = 0, m_rd = 0;
  bit e_ack, e_nak, e_rej, e_rdone;
  int e_rval = 0;

  int nvalid = 0;
  logic [15:0] last_bcd = '0;

  coin_credit_bcd dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .coin_pulse   (coin_pulse),
    .vend_req     (vend_req),
    .vend_price   (vend_price),
`ifdef REFUND_EN
    .refund_req   (refund_req),
    .refund_val   (refund_val),
    .refund_done  (refund_done),
`endif
    .vend_ack     (vend_ack),
    .vend_nak     (vend_nak),
    .coin_reject  (coin_reject),
    .coin_val_sum (coin_val_sum),
    .sum_bcd      (sum_bcd),
    .bcd_valid    (bcd_valid),
    .bcd_busy     (bcd_busy)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk)
    if (sys_rst_n && bcd_valid) begin
      nvalid = nvalid + 1;
      last_bcd = sum_bcd;
    end

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < 4; k++) begin
      r[k*4 +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Drive one cycle of inputs and advance the model.
  task automatic step(input logic [2:0] c, input bit vr,
                      input int pr, input bit rr);
    int add, base;
    bit ve, re;
    coin_pulse = c;
    vend_req = vr;
    vend_price = 11'(pr);
`ifdef REFUND_EN
    refund_req = rr;
    re = rr && !m_rd;
`else
    re = 0;
`endif
    add = (c[0] ? 10 : 0) + (c[1] ? 50 : 0) + (c[2] ? 100 : 0);
    ve = vr && !m_vd;
    e_ack = ve && !re && (m_credit >= pr);
    e_nak = ve && !e_ack;
    e_rdone = re;
    if (re) e_rval = m_credit;
    if (re) base = 0;
    else if (e_ack) base = m_credit - pr;
    else base = m_credit;
    e_rej = (base + add > 1999);
    m_credit = e_rej ? base : base + add;
    m_vd = vr;
    m_rd = rr;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) step(3'b000, 0, 0, 0);
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b0;
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1;
    n_chk++;
    if ({vend_ack, vend_nak, coin_reject, bcd_valid, bcd_busy} !== 5'b0)
      $display("FAIL reset_flags got=%b want=0",
        {vend_ack, vend_nak, coin_reject, bcd_valid, bcd_busy});
    else n_pass++;
    n_chk++;
    if ({coin_val_sum, sum_bcd} !== 27'b0)
      $display("FAIL reset_values credit=%0d bcd=%h want=0",
        coin_val_sum, sum_bcd);
    else n_pass++;
    sys_rst_n = 1'b1;
    m_credit = 0;
    settle(3);
    n_chk++;
    if (nvalid !== 0)
      $display("FAIL reset_noconv got=%0d want=0", nvalid);
    else n_pass++;
  endtask

  task automatic test_coins;
    int want[4] = '{100, 200, 300, 350};
    logic [2:0] ch[4] = '{3'b100, 3'b100, 3'b100, 3'b010};
    for (int i = 0; i < 4; i++) begin
      step(ch[i], 0, 0, 0);
      n_chk++;
      if (coin_val_sum !== 11'(want[i]))
        $display("FAIL coin_sum%0d got=%0d want=%0d",
          i, coin_val_sum, want[i]);
      else n_pass++;
    end
    settle(40);
    n_chk++;
    if (last_bcd !== 16'h0350 || sum_bcd !== 16'h0350)
      $display("FAIL coin_bcd got=%h/%h want=0350", last_bcd, sum_bcd);
    else n_pass++;
  endtask

  task automatic test_vend;
    step(3'b000, 1, 300, 0);
    n_chk++;
    if (vend_ack !== 1'b1 || vend_nak !== 1'b0 || coin_val_sum !== 11'd50)
      $display("FAIL vend_ack got=%b%b %0d want=10 50",
        vend_ack, vend_nak, coin_val_sum);
    else n_pass++;
    step(3'b000, 0, 0, 0);
    step(3'b000, 1, 100, 0);
    n_chk++;
    if (vend_nak !== 1'b1 || vend_ack !== 1'b0 || coin_val_sum !== 11'd50)
      $display("FAIL vend_nak got=%b%b %0d want=01 50",
        vend_ack, vend_nak, coin_val_sum);
    else n_pass++;
    step(3'b000, 1, 0, 0);
    n_chk++;
    if ({vend_ack, vend_nak} !== {e_ack, e_nak} || vend_ack !== 1'b0)
      $display("FAIL vend_held got=%b%b want=00", vend_ack, vend_nak);
    else n_pass++;
    step(3'b000, 0, 0, 0);
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 19; i++) step(3'b100, 0, 0, 0);
    n_chk++;
    if (coin_val_sum !== 11'd1950)
      $display("FAIL sat_fill got=%0d want=1950", coin_val_sum);
    else n_pass++;
    step(3'b010, 0, 0, 0);
    n_chk++;
    if (coin_reject !== 1'b1 || coin_val_sum !== 11'd1950)
      $display("FAIL sat_rej1 got=%b %0d want=1 1950",
        coin_reject, coin_val_sum);
    else n_pass++;
    step(3'b001, 0, 0, 0);
    n_chk++;
    if (coin_reject !== 1'b0 || coin_val_sum !== 11'd1960)
      $display("FAIL sat_ok got=%b %0d want=0 1960",
        coin_reject, coin_val_sum);
    else n_pass++;
    step(3'b111, 0, 0, 0);
    n_chk++;
    if (coin_reject !== 1'b1 || coin_val_sum !== 11'd1960)
      $display("FAIL sat_rej3 got=%b %0d want=1 1960",
        coin_reject, coin_val_sum);
    else n_pass++;
  endtask

  task automatic test_simultaneous;
    step(3'b000, 1, 1910, 0);
    step(3'b000, 0, 0, 0);
    n_chk++;
    if (coin_val_sum !== 11'd50)
      $display("FAIL simul_pre got=%0d want=50", coin_val_sum);
    else n_pass++;
    step(3'b100, 1, 50, 0);
    n_chk++;
    if (vend_ack !== 1'b1 || coin_val_sum !== 11'd100)
      $display("FAIL simul got=%b %0d want=1 100", vend_ack, coin_val_sum);
    else n_pass++;
    step(3'b000, 0, 0, 0);
    settle(40);
  endtask

  task automatic test_latency;
    int lat;
    lat = -1;
    nvalid = 0;
    step(3'b001, 0, 0, 0);
    step(3'b000, 0, 0, 0);
    n_chk++;
    if (bcd_busy !== 1'b1)
      $display("FAIL lat_busy got=%b want=1", bcd_busy);
    else n_pass++;
    for (int i = 2; i <= 30; i++) begin
      step(3'b000, 0, 0, 0);
      if (bcd_valid === 1'b1 && lat < 0) lat = i;
    end
    n_chk++;
    if (lat !== 13)
      $display("FAIL lat_cycles got=%0d want=13", lat);
    else n_pass++;
    n_chk++;
    if (sum_bcd !== 16'h0110 || nvalid !== 1)
      $display("FAIL lat_bcd got=%h n=%0d want=0110 n=1", sum_bcd, nvalid);
    else n_pass++;
  endtask

  task automatic test_restart;
    nvalid = 0;
    step(3'b100, 0, 0, 0);
    settle(5);
    step(3'b001, 0, 0, 0);
    settle(40);
    n_chk++;
    if (nvalid !== 2)
      $display("FAIL restart_cnt got=%0d want=2", nvalid);
    else n_pass++;
    n_chk++;
    if (last_bcd !== 16'h0220)
      $display("FAIL restart_bcd got=%h want=0220", last_bcd);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    step(3'b100, 0, 0, 0);
    settle(4);
    #1 sys_rst_n = 1'b0;
    #2;
    n_chk++;
    if ({vend_ack, vend_nak, coin_reject, bcd_valid, bcd_busy} !== 5'b0)
      $display("FAIL rstmid_flags got=%b want=0",
        {vend_ack, vend_nak, coin_reject, bcd_valid, bcd_busy});
    else n_pass++;
    n_chk++;
    if ({coin_val_sum, sum_bcd} !== 27'b0)
      $display("FAIL rstmid_values credit=%0d bcd=%h want=0",
        coin_val_sum, sum_bcd);
    else n_pass++;
    #2 sys_rst_n = 1'b1;
    m_credit = 0;
    m_vd = 0;
    m_rd = 0;
    e_rval = 0;
    nvalid = 0;
    @(posedge sys_clk);
    #1;
    settle(20);
    n_chk++;
    if (nvalid !== 0 || sum_bcd !== 16'h0)
      $display("FAIL rstmid_idle n=%0d bcd=%h want=0", nvalid, sum_bcd);
    else n_pass++;
  endtask

  task automatic test_random;
    logic [2:0] c;
    bit vr;
    int pr;
    for (int i = 0; i < 400; i++) begin
      c = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'b0;
      vr = ($urandom_range(0, 3) != 0) ? !m_vd : m_vd;
      pr = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 600));
      step(c, vr, pr, 0);
      n_chk++;
      if (coin_val_sum !== 11'(m_credit))
        $display("FAIL rnd_credit%0d got=%0d want=%0d",
          i, coin_val_sum, m_credit);
      else n_pass++;
      n_chk++;
      if ({vend_ack, vend_nak, coin_reject} !== {e_ack, e_nak, e_rej})
        $display("FAIL rnd_flags%0d got=%b want=%b", i,
          {vend_ack, vend_nak, coin_reject}, {e_ack, e_nak, e_rej});
      else n_pass++;
    end
    step(3'b000, 0, 0, 0);
    settle(40);
    n_chk++;
    if (sum_bcd !== to_bcd(m_credit))
      $display("FAIL rnd_bcd got=%h want=%h", sum_bcd, to_bcd(m_credit));
    else n_pass++;
  endtask

`ifdef REFUND_EN
  task automatic test_refund;
    step(3'b000, 0, 0, 1);
    step(3'b000, 0, 0, 0);
    step(3'b100, 0, 0, 0);
    step(3'b001, 0, 0, 0);
    step(3'b001, 0, 0, 0);
    settle(40);
    step(3'b000, 0, 0, 1);
    n_chk++;
    if (refund_done !== 1'b1 || refund_val !== 11'd120 ||
        coin_val_sum !== 11'd0)
      $display("FAIL refund got=%b %0d %0d want=1 120 0",
        refund_done, refund_val, coin_val_sum);
    else n_pass++;
    step(3'b000, 0, 0, 0);
    settle(40);
    n_chk++;
    if (sum_bcd !== 16'h0000 || refund_val !== 11'(e_rval))
      $display("FAIL refund_bcd got=%h %0d want=0000 %0d",
        sum_bcd, refund_val, e_rval);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset;
    test_coins;
    test_vend;
    test_saturation;
    test_simultaneous;
    test_latency;
    test_restart;
    test_reset_mid;
    test_random;
`ifdef REFUND_EN
    test_refund;
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
